// File: rtl/softmax_row_sequencer.sv
// Streams ROWS x N words from input BRAM to an external softmax core, writes results back per row; row latency 2N+3+L_sm cycles.
// No backpressure: core result accepted whenever it arrives in WAIT_SM, memories assumed always ready.
module softmax_row_sequencer #(
  parameter int N         = 32,
  parameter int BIT_WIDTH = 16,
  parameter int MAX_ROWS  = 64,
  parameter int ADDR_W    = $clog2(N*MAX_ROWS),
  parameter int ROW_W     = $clog2(MAX_ROWS+1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [ROW_W-1:0]       i_num_rows,
  output logic                   o_rd_en,
  output logic [ADDR_W-1:0]      o_rd_addr,
  input  logic [BIT_WIDTH-1:0]   i_rd_data,
  output logic                   o_sm_valid,
  output logic [N*BIT_WIDTH-1:0] o_sm_data,
  input  logic                   i_sm_valid,
  input  logic [N*BIT_WIDTH-1:0] i_sm_data,
  output logic                   o_wr_en,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [BIT_WIDTH-1:0]   o_wr_data,
  output logic                   o_busy,
  output logic [ROW_W-1:0]       o_row_idx,
  output logic                   o_row_done,
  output logic                   o_done
);

  localparam int CNT_W    = $clog2(N+1);
  localparam int ROW_BITS = N*BIT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT_SM, S_WRITE, S_ROW_END, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    rows, row;
  logic [ROW_W-1:0]    num_rows_clamped;
  logic [CNT_W-1:0]    cnt;
  logic [ROW_BITS-1:0] inbuf, outbuf;
  logic                fetch_last, write_last, row_last;
  logic [ADDR_W-1:0]   elem_addr;

  assign num_rows_clamped = (i_num_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : i_num_rows;
  assign fetch_last = (cnt == CNT_W'(N));
  assign write_last = (cnt == CNT_W'(N-1));
  assign row_last   = (row == rows - ROW_W'(1));
  assign elem_addr  = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(cnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start) state_nxt = (num_rows_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetch_last) state_nxt = S_SEND;
      S_SEND:    state_nxt = S_WAIT_SM;
      S_WAIT_SM: if (i_sm_valid) state_nxt = S_WRITE;
      S_WRITE:   if (write_last) state_nxt = S_ROW_END;
      S_ROW_END: state_nxt = row_last ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so capture runs on counts 1..N and
  // shifts in from the top; element 0 lands in the low slice after N shifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rows   <= '0;
      row    <= '0;
      cnt    <= '0;
      inbuf  <= '0;
      outbuf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_start) begin
            rows <= num_rows_clamped;
            row  <= '0;
          end
        end
        S_FETCH: begin
          if (cnt != '0) inbuf <= {i_rd_data, inbuf[ROW_BITS-1:BIT_WIDTH]};
          cnt <= fetch_last ? '0 : cnt + CNT_W'(1);
        end
        S_WAIT_SM: if (i_sm_valid) outbuf <= i_sm_data;
        S_WRITE: begin
          outbuf <= outbuf >> BIT_WIDTH;
          cnt    <= write_last ? '0 : cnt + CNT_W'(1);
        end
        S_ROW_END: if (!row_last) row <= row + ROW_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rd_en    = 1'b0;
    o_rd_addr  = '0;
    o_wr_en    = 1'b0;
    o_wr_addr  = '0;
    o_wr_data  = '0;
    o_sm_valid = (state == S_SEND);
    o_sm_data  = inbuf;
    o_busy     = (state != S_IDLE);
    o_row_idx  = row;
    o_row_done = (state == S_ROW_END);
    o_done     = (state == S_DONE);
    if (state == S_FETCH && !fetch_last) begin
      o_rd_en   = 1'b1;
      o_rd_addr = elem_addr;
    end
    if (state == S_WRITE) begin
      o_wr_en   = 1'b1;
      o_wr_addr = elem_addr;
      o_wr_data = outbuf[BIT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_softmax_row_sequencer.sv
// Directed bench: BRAM word at address a holds a, core model returns each element +1 three cycles after the row pulse.
module tb_softmax_row_sequencer;
  localparam int N = 32, BW = 16, MAX_ROWS = 64, ADDR_W = 11, ROW_W = 7, LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, rd_en, sm_valid_o, sm_valid_i, wr_en, busy, row_done, done, spur;
  logic [ROW_W-1:0]  num_rows, row_idx;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [BW-1:0]     rd_data, wr_data;
  logic [N*BW-1:0]   sm_data_o, sm_data_i, sm_res;
  logic [LAT-1:0]    sm_pipe;

  int checks = 0, failures = 0;
  int rd_cnt, rd_ok, wr_cnt, wr_ok, last_wr_addr, sm_cnt, sm_ok, sm_cycle;
  int rdone_cnt, rdone_first, ridx_ok, done_cnt, done_cycle, busy_after;

  softmax_row_sequencer #(.N(N), .BIT_WIDTH(BW), .MAX_ROWS(MAX_ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_rows(num_rows),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_sm_valid(sm_valid_o), .o_sm_data(sm_data_o), .i_sm_valid(sm_valid_i), .i_sm_data(sm_data_i),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_row_idx(row_idx), .o_row_done(row_done), .o_done(done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= BW'(rd_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_pipe <= '0;
      sm_res  <= '0;
    end else begin
      sm_pipe <= {sm_pipe[LAT-2:0], sm_valid_o};
      if (sm_valid_o)
        for (int k = 0; k < N; k++) sm_res[k*BW +: BW] <= sm_data_o[k*BW +: BW] + 16'd1;
    end
  end
  assign sm_valid_i = sm_pipe[LAT-1] | spur;
  assign sm_data_i  = sm_res;

  // Pulses start in the current cycle (cycle 0) and records what the DUT does on each later cycle.
  task automatic run_job(input int nrows, input int budget, input bit start_in_wait,
                         input bit spur_fetch, input int stop_at_wr);
    bit ok;
    rd_cnt = 0; rd_ok = 0; wr_cnt = 0; wr_ok = 0; last_wr_addr = -1; sm_cnt = 0; sm_ok = 0;
    sm_cycle = -1; rdone_cnt = 0; rdone_first = -1; ridx_ok = 0; done_cnt = 0;
    done_cycle = -1; busy_after = -1;
    start = 1'b1;
    num_rows = ROW_W'(nrows);
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (start_in_wait && sm_cycle >= 0 && c == sm_cycle + 1) begin
        start = 1'b1;
        num_rows = ROW_W'(5);
      end
      spur = spur_fetch && (c == 5 || c == 6);
      if (rd_en) begin
        if (rd_addr == ADDR_W'(rd_cnt)) rd_ok++;
        rd_cnt++;
      end
      if (sm_valid_o) begin
        ok = 1'b1;
        for (int k = 0; k < N; k++)
          if (sm_data_o[k*BW +: BW] != BW'(sm_cnt*N + k)) ok = 1'b0;
        if (ok) sm_ok++;
        if (sm_cycle < 0) sm_cycle = c;
        sm_cnt++;
      end
      if (wr_en) begin
        if (wr_addr == ADDR_W'(wr_cnt) && wr_data == BW'(wr_cnt + 1)) wr_ok++;
        last_wr_addr = int'(wr_addr);
        wr_cnt++;
        if (wr_cnt == stop_at_wr) begin
          start = 1'b0; spur = 1'b0;
          return;
        end
      end
      if (row_done) begin
        if (rdone_first < 0) rdone_first = c;
        if (row_idx == ROW_W'(rdone_cnt)) ridx_ok++;
        rdone_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c == done_cycle + 1) busy_after = int'(busy);
      if (done_cycle >= 0 && c == done_cycle + 3) break;
    end
    start = 1'b0;
    spur = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0; start = 1'b0; num_rows = '0; spur = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b%b exp=00", rd_en, wr_en); end
    checks++; if (sm_data_o !== '0) begin failures++; $display("FAIL rst_sm_data got=%h exp=0", sm_data_o); end
    checks++; if (row_idx !== '0 || done !== 1'b0 || row_done !== 1'b0 || sm_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_flags got idx=%0d done=%b rdone=%b smv=%b exp=0", row_idx, done, row_done, sm_valid_o); end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ({busy, rd_en, wr_en, sm_valid_o, row_done, done} !== 6'b0 || rd_addr !== '0 ||
          wr_addr !== '0 || wr_data !== '0 || row_idx !== '0 || sm_data_o !== '0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL idle_outputs got=%0d nonzero_cycles exp=0", bad); end
  endtask

  task automatic test_single_row;
    run_job(1, 200, 1'b0, 1'b0, -1);
    checks++; if (rd_cnt !== 32 || rd_ok !== 32) begin failures++; $display("FAIL one_reads got=%0d/%0d exp=32/32", rd_ok, rd_cnt); end
    checks++; if (sm_cnt !== 1 || sm_ok !== 1) begin failures++; $display("FAIL one_sm got=%0d/%0d exp=1/1", sm_ok, sm_cnt); end
    checks++; if (wr_cnt !== 32 || wr_ok !== 32) begin failures++; $display("FAIL one_writes got=%0d/%0d exp=32/32", wr_ok, wr_cnt); end
    checks++; if (rdone_first !== 70 || rdone_cnt !== 1) begin failures++; $display("FAIL one_row_done got=cyc%0d n%0d exp=cyc70 n1", rdone_first, rdone_cnt); end
    checks++; if (done_cycle !== 71 || done_cnt !== 1) begin failures++; $display("FAIL one_done got=cyc%0d n%0d exp=cyc71 n1", done_cycle, done_cnt); end
    checks++; if (busy_after !== 0) begin failures++; $display("FAIL one_busy_after got=%0d exp=0", busy_after); end
  endtask

  task automatic test_three_rows;
    run_job(3, 400, 1'b0, 1'b0, -1);
    checks++; if (rd_cnt !== 96 || rd_ok !== 96) begin failures++; $display("FAIL three_reads got=%0d/%0d exp=96/96", rd_ok, rd_cnt); end
    checks++; if (wr_cnt !== 96 || wr_ok !== 96) begin failures++; $display("FAIL three_writes got=%0d/%0d exp=96/96", wr_ok, wr_cnt); end
    checks++; if (sm_ok !== 3) begin failures++; $display("FAIL three_sm got=%0d exp=3", sm_ok); end
    checks++; if (rdone_cnt !== 3 || ridx_ok !== 3) begin failures++; $display("FAIL three_row_idx got=%0d/%0d exp=3/3", ridx_ok, rdone_cnt); end
    checks++; if (done_cycle !== 211 || done_cnt !== 1) begin failures++; $display("FAIL three_done got=cyc%0d n%0d exp=cyc211 n1", done_cycle, done_cnt); end
  endtask

  task automatic test_zero_rows;
    run_job(0, 20, 1'b0, 1'b0, -1);
    checks++; if (done_cycle !== 1 || done_cnt !== 1) begin failures++; $display("FAIL zero_done got=cyc%0d n%0d exp=cyc1 n1", done_cycle, done_cnt); end
    checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin failures++; $display("FAIL zero_mem got=rd%0d wr%0d exp=0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_clamp;
    run_job(100, 5000, 1'b0, 1'b0, -1);
    checks++; if (rdone_cnt !== 64 || ridx_ok !== 64) begin failures++; $display("FAIL clamp_rows got=%0d/%0d exp=64/64", ridx_ok, rdone_cnt); end
    checks++; if (last_wr_addr !== 2047 || wr_ok !== 2048) begin failures++; $display("FAIL clamp_writes got=last%0d ok%0d exp=last2047 ok2048", last_wr_addr, wr_ok); end
    checks++; if (done_cycle !== 4481) begin failures++; $display("FAIL clamp_done got=%0d exp=4481", done_cycle); end
  endtask

  task automatic test_start_in_wait;
    run_job(1, 200, 1'b1, 1'b0, -1);
    checks++; if (done_cycle !== 71 || done_cnt !== 1) begin failures++; $display("FAIL wstart_done got=cyc%0d n%0d exp=cyc71 n1", done_cycle, done_cnt); end
    checks++; if (rd_cnt !== 32 || wr_ok !== 32 || sm_cnt !== 1) begin failures++; $display("FAIL wstart_traffic got=rd%0d wr%0d sm%0d exp=32/32/1", rd_cnt, wr_ok, sm_cnt); end
  endtask

  task automatic test_spurious_sm_valid;
    run_job(2, 400, 1'b0, 1'b1, -1);
    checks++; if (wr_cnt !== 64 || wr_ok !== 64) begin failures++; $display("FAIL spur_writes got=%0d/%0d exp=64/64", wr_ok, wr_cnt); end
    checks++; if (done_cycle !== 141 || sm_ok !== 2) begin failures++; $display("FAIL spur_done got=cyc%0d sm%0d exp=cyc141 sm2", done_cycle, sm_ok); end
  endtask

  task automatic test_reset_mid_job;
    run_job(2, 400, 1'b0, 1'b0, N + 5);
    checks++; if (wr_cnt !== N + 5) begin failures++; $display("FAIL mid_reach_write got=%0d exp=%0d", wr_cnt, N + 5); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, rd_en, wr_en, sm_valid_o, row_done, done} !== 6'b0 || wr_addr !== '0 || wr_data !== '0) begin
      failures++; $display("FAIL mid_rst_outputs got=busy%b wr%b addr%0d exp=0", busy, wr_en, wr_addr); end
    checks++; if (row_idx !== '0 || sm_data_o !== '0) begin failures++; $display("FAIL mid_rst_state got=idx%0d exp=0", row_idx); end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL mid_after_release got=busy%b wr%b exp=0", busy, wr_en); end
    run_job(1, 200, 1'b0, 1'b0, -1);
    checks++; if (rd_cnt !== 32 || rd_ok !== 32 || wr_ok !== 32) begin failures++; $display("FAIL mid_rerun got=rd%0d wr%0d exp=32/32", rd_ok, wr_ok); end
    checks++; if (done_cycle !== 71 || ridx_ok !== 1 || sm_ok !== 1) begin failures++; $display("FAIL mid_rerun_done got=cyc%0d idx%0d sm%0d exp=71/1/1", done_cycle, ridx_ok, sm_ok); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_three_rows();
    test_zero_rows();
    test_clamp();
    test_start_in_wait();
    test_spurious_sm_valid();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_row_sequencer.md
Name: softmax_row_sequencer

Overview:
Parametrised multi-row successor to the single-row softmax top. It streams ROWS×N input words from an input BRAM, assembles each row and hands it to an external softmax core with a valid pulse. It captures the returned row and serialises it into an output BRAM at the matching row base address. It repeats this for a run-time row count and signals per-row and end-of-job completion.

Parameters:
N, 32, elements per row (≥2)
BIT_WIDTH, 16, element width (input signed, output unsigned Q0.BIT_WIDTH)
MAX_ROWS, 64, maximum rows per job
ADDR_W, $clog2(N*MAX_ROWS), memory word-address width (derived)
ROW_W, $clog2(MAX_ROWS+1), row-count width (derived)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  job start pulse; sampled only in IDLE
i_num_rows  in  ROW_W  rows in job; sampled with i_start
o_rd_en  out  1  input BRAM read enable
o_rd_addr  out  ADDR_W  input BRAM address
i_rd_data  in  BIT_WIDTH  input BRAM data, valid 1 cycle after o_rd_en
o_sm_valid  out  1  one-cycle pulse: o_sm_data holds a complete row
o_sm_data  out  N*BIT_WIDTH  row to softmax core, element k at [k*BIT_WIDTH +: BIT_WIDTH]
i_sm_valid  in  1  softmax result valid
i_sm_data  in  N*BIT_WIDTH  softmax result row, same packing
o_wr_en  out  1  output BRAM write enable
o_wr_addr  out  ADDR_W  output BRAM address
o_wr_data  out  BIT_WIDTH  output BRAM data
o_busy  out  1  high in every state except IDLE
o_row_idx  out  ROW_W  index of the row in progress
o_row_done  out  1  one-cycle pulse after the last write of a row
o_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE. All outputs 0, row/element counters 0, row buffers 0.
- States: IDLE, FETCH, SEND, WAIT_SM, WRITE, ROW_END, DONE.
- IDLE: on i_start, latch rows = min(i_num_rows, MAX_ROWS) and set row=0.
  - rows==0 → DONE; no memory access.
  - Otherwise → FETCH.
  - i_start in any other state is ignored; no restart.
- FETCH: N+1 cycles.
  - Cycles k=0..N-1: o_rd_en=1, o_rd_addr=row*N+k.
  - Cycles 1..N: capture i_rd_data into inbuf[k-1].
  - Then → SEND.
- SEND: one cycle, o_sm_valid=1, o_sm_data=inbuf (held stable until the next FETCH). → WAIT_SM.
- WAIT_SM: wait indefinitely. On i_sm_valid, capture i_sm_data into outbuf → WRITE.
  - i_sm_valid in any other state is ignored.
  - Required core latency is ≥1 cycle after o_sm_valid.
- WRITE: N cycles. Cycle k: o_wr_en=1, o_wr_addr=row*N+k, o_wr_data=outbuf[k]. → ROW_END.
- ROW_END: one cycle, o_row_done=1.
  - If row==rows-1 → DONE.
  - Else row++ → FETCH.
- DONE: one cycle, o_done=1 → IDLE. o_busy=1 in DONE.
- o_row_idx = current row; holds the last value in IDLE until the next start.
- Addresses: row*N+k computed in ADDR_W bits. Max address N*MAX_ROWS-1, so no wrap.
- Per-row latency from FETCH entry to o_row_done = N+1 + 1 + L_sm + N + 1 cycles, where L_sm = cycles from SEND to i_sm_valid.
- Reset mid-job: immediate return to IDLE with all outputs 0. A partial row may remain in the output BRAM; no further writes occur.
- i_num_rows > MAX_ROWS: clamped to MAX_ROWS.

Test Plan:
- Reset then idle, no start → all outputs 0 for 20 cycles; o_busy=0.
- N=32, i_num_rows=1, input BRAM word k = k, core model returns row+1 after 3 cycles:
  - o_rd_addr 0..31 on 32 consecutive cycles;
  - o_sm_valid single pulse carrying 0..31;
  - o_wr_addr 0..31 with data 1..32;
  - o_row_done, then o_done, 71 cycles after start (33+1+3+32+1+1).
- i_num_rows=3 → reads 0..95, writes 0..95; o_row_idx 0,1,2; three o_row_done pulses, one o_done.
- i_num_rows=0 → o_done one cycle after start; o_rd_en and o_wr_en never asserted.
- i_num_rows=100 with MAX_ROWS=64 → exactly 64 o_row_done pulses; last o_wr_addr = 2047.
- Mid-job events:
  - i_start pulsed during WAIT_SM → ignored, job completes normally.
  - Spurious i_sm_valid during FETCH → not captured.
  - i_rst_n low during WRITE of row 1 → outputs 0 immediately, state IDLE; a new start runs cleanly from row 0.
